mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: CPU read/write and write-only PS/2 keyboard share one
// single-port memory through a fixed three-cycle IDLE -> ACCESS -> ACK sequence.
module mem_port_arbiter #(
  parameter logic [15:0] KBD_BASE = 16'hFFF0,
  parameter int unsigned KBD_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        kbd_req,
  input  logic [15:0] kbd_addr,
  input  logic [15:0] kbd_wdata,
  output logic        kbd_ack,
  output logic        kbd_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  // state  | meaning
  // IDLE   | sample requests, pick winner, launch memory strobe
  // ACCESS | memory strobe cycle (suppressed for a rejected keyboard write)
  // ACK    | pulse winner's ack, capture CPU read data
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t state, state_nxt;

  logic        last_kbd;
  logic        win_kbd, win_we, win_ok;
  logic        any_req, pick_kbd, kbd_in_win;
  logic        sel_we, sel_ok;
  logic [15:0] sel_addr, sel_wdata;
  logic [16:0] win_lo, win_hi, kbd_addr_x;

  logic        mem_en_nxt, mem_we_nxt, cpu_ack_nxt, kbd_ack_nxt, kbd_err_nxt;
  logic [15:0] mem_addr_nxt, mem_wdata_nxt, cpu_rdata_nxt;

  // Window bounds in 17 bits so a window ending at 16'hFFFF does not wrap.
  assign kbd_addr_x = {1'b0, kbd_addr};
  assign win_lo     = {1'b0, KBD_BASE};
  assign win_hi     = win_lo + 17'(KBD_SIZE);
  assign kbd_in_win = (kbd_addr_x >= win_lo) && (kbd_addr_x < win_hi);

  assign any_req   = cpu_req | kbd_req;
  assign pick_kbd  = kbd_req && (!cpu_req || !last_kbd);
  assign sel_we    = pick_kbd ? 1'b1 : cpu_we;
  assign sel_addr  = pick_kbd ? kbd_addr : cpu_addr;
  assign sel_wdata = pick_kbd ? kbd_wdata : cpu_wdata;
  assign sel_ok    = !pick_kbd || kbd_in_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_ACK;
      S_ACK:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Winner bookkeeping; last_kbd resets to 1 so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_kbd <= 1'b1;
      win_kbd  <= 1'b0;
      win_we   <= 1'b0;
      win_ok   <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      last_kbd <= pick_kbd;
      win_kbd  <= pick_kbd;
      win_we   <= sel_we;
      win_ok   <= sel_ok;
    end
  end

  always_comb begin
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    cpu_ack_nxt   = 1'b0;
    kbd_ack_nxt   = 1'b0;
    kbd_err_nxt   = 1'b0;
    cpu_rdata_nxt = cpu_rdata;
    case (state)
      S_IDLE: begin
        if (any_req && sel_ok) begin
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = sel_we;
          mem_addr_nxt  = sel_addr;
          mem_wdata_nxt = sel_wdata;
        end
      end
      S_ACCESS: begin
        if (win_kbd) begin
          kbd_ack_nxt = 1'b1;
          kbd_err_nxt = !win_ok;
        end else begin
          cpu_ack_nxt = 1'b1;
        end
      end
      S_ACK: begin
        // Read data arrives the cycle after the strobe, i.e. during ACK.
        if (!win_kbd && !win_we) cpu_rdata_nxt = mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      cpu_ack   <= 1'b0;
      kbd_ack   <= 1'b0;
      kbd_err   <= 1'b0;
      cpu_rdata <= 16'h0000;
    end else begin
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      cpu_ack   <= cpu_ack_nxt;
      kbd_ack   <= kbd_ack_nxt;
      kbd_err   <= kbd_err_nxt;
      cpu_rdata <= cpu_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing cases plus randomized traffic,
// with a scoreboard monitor checking every ack against queued expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        kbd_req, kbd_ack, kbd_err;
  logic [15:0] kbd_addr, kbd_wdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .kbd_req(kbd_req), .kbd_addr(kbd_addr), .kbd_wdata(kbd_wdata),
    .kbd_ack(kbd_ack), .kbd_err(kbd_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {logic we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] rdata;} cpu_txn_t;
  typedef struct {logic [15:0] addr; logic [15:0] wdata; logic err;} kbd_txn_t;

  cpu_txn_t    cpu_q[$];
  kbd_txn_t    kbd_q[$];
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          n_vec = 0;
  int          n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: no ack within cycle budget", name);
  endfunction

  function automatic bit kbd_bad(input logic [15:0] a);
    int ai;
    ai = int'(a);
    return !(ai >= 'hFFF0 && ai < 'hFFF0 + 16);
  endfunction

  function automatic logic [15:0] init_word(input int i);
    return (i == 'h0010) ? 16'hBEEF : (16'(i) ^ 16'h5A5A);
  endfunction

  // Synchronous memory: read data valid the cycle after the strobe.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_word(i);
    mem_rdata = 16'h0000;
    forever @(posedge clk) begin
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic        p_en, p_we, pend;
    logic [15:0] p_addr, p_wdata, pend_val;
    cpu_txn_t    ce;
    kbd_txn_t    ke;
    p_en = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0; pend = 1'b0; pend_val = '0;
    forever @(negedge clk) begin
      if (!rst_n) begin
        p_en = 1'b0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("sb_cpu_rdata", cpu_rdata, pend_val);
          pend = 1'b0;
        end
        if (cpu_ack) begin
          if (cpu_q.size() == 0) chk("sb_cpu_ack_unexpected", cpu_ack, 1'b0);
          else begin
            ce = cpu_q.pop_front();
            chk("sb_cpu_strobe", p_en, 1'b1);
            chk("sb_cpu_we", p_we, ce.we);
            chk("sb_cpu_addr", p_addr, ce.addr);
            if (ce.we) chk("sb_cpu_wdata", p_wdata, ce.wdata);
            else begin
              pend = 1'b1;
              pend_val = ce.rdata;
            end
          end
        end
        if (kbd_ack) begin
          if (kbd_q.size() == 0) chk("sb_kbd_ack_unexpected", kbd_ack, 1'b0);
          else begin
            ke = kbd_q.pop_front();
            chk("sb_kbd_err", kbd_err, ke.err);
            chk("sb_kbd_strobe", p_en, !ke.err);
            if (!ke.err) begin
              chk("sb_kbd_we", p_we, 1'b1);
              chk("sb_kbd_addr", p_addr, ke.addr);
              chk("sb_kbd_wdata", p_wdata, ke.wdata);
            end
          end
        end else if (kbd_err) chk("sb_kbd_err_without_ack", kbd_err, 1'b0);
        if (cpu_ack && kbd_ack) chk("sb_dual_ack", 1'b1, 1'b0);
        p_en = mem_en; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      end
    end
  end

  task automatic issue_cpu(input logic we, input logic [15:0] a, input logic [15:0] d);
    cpu_txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    t.rdata = we ? 16'h0000 : ref_mem[a];
    cpu_q.push_back(t);
    if (we) ref_mem[a] = d;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
  endtask

  task automatic issue_kbd(input logic [15:0] a, input logic [15:0] d);
    kbd_txn_t t;
    t.addr = a; t.wdata = d; t.err = kbd_bad(a);
    kbd_q.push_back(t);
    if (!t.err) ref_mem[a] = d;
    kbd_addr = a; kbd_wdata = d; kbd_req = 1'b1;
  endtask

  task automatic wait_cpu();
    int n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ack && n < 40);
    if (!cpu_ack) timeout("cpu_ack_timeout");
    cpu_req = 1'b0;
  endtask

  task automatic wait_kbd();
    int n = 0;
    do begin @(negedge clk); n++; end while (!kbd_ack && n < 40);
    if (!kbd_ack) timeout("kbd_ack_timeout");
    kbd_req = 1'b0;
  endtask

  task automatic drain();
    if (cpu_req) wait_cpu();
    if (kbd_req) wait_kbd();
  endtask

  // Samples strobe cycle (1) and ack cycle (2) of a single transaction.
  task automatic step3(output logic en1, output logic we1, output logic [15:0] a1,
                       output logic ca2, output logic ka2, output logic ke2);
    @(negedge clk);
    en1 = mem_en; we1 = mem_we; a1 = mem_addr;
    @(negedge clk);
    ca2 = cpu_ack; ka2 = kbd_ack; ke2 = kbd_err;
    if (cpu_ack) cpu_req = 1'b0;
    if (kbd_ack) kbd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        en1, we1, ca2, ka2, ke2;
    logic [15:0] a1;
    logic        en[1:5], ca[1:5], ka[1:5];
    logic [15:0] ad[1:5];
    int          order[$];
    int          n, bad;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    kbd_req = 0; kbd_addr = '0; kbd_wdata = '0;
    #1;
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_acks", {cpu_ack, kbd_ack, kbd_err, mem_we}, 4'b0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
    repeat (2) @(negedge clk);

    // Simultaneous requests right after reset: CPU wins the first tie.
    rst_n = 1'b1;
    issue_cpu(1'b1, 16'h0020, 16'h1234);
    issue_kbd(16'hFFF3, 16'h0041);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      en[c] = mem_en; ca[c] = cpu_ack; ka[c] = kbd_ack; ad[c] = mem_addr;
      if (cpu_ack) cpu_req = 1'b0;
      if (kbd_ack) kbd_req = 1'b0;
    end
    chk("tie_cpu_en_c1", en[1], 1'b1);
    chk("tie_cpu_addr_c1", ad[1], 16'h0020);
    chk("tie_cpu_ack_c2", ca[2], 1'b1);
    chk("tie_kbd_en_c4", en[4], 1'b1);
    chk("tie_kbd_addr_c4", ad[4], 16'hFFF3);
    chk("tie_kbd_ack_c5", ka[5], 1'b1);
    drain();

    // Both requests held: grants must alternate.
    @(negedge clk);
    issue_cpu(1'b1, 16'h0040, 16'hAAAA);
    issue_cpu(1'b1, 16'h0040, 16'hAAAA);
    issue_kbd(16'hFFF5, 16'h1111);
    issue_kbd(16'hFFF5, 16'h1111);
    n = 0;
    while (order.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_ack) order.push_back(0);
      if (kbd_ack) order.push_back(1);
    end
    cpu_req = 1'b0; kbd_req = 1'b0;
    chk("rr_count", order.size(), 4);
    chk("rr_cycles", n, 11);
    for (int i = 0; i < order.size() && i < 4; i++) chk($sformatf("rr_grant%0d", i), order[i], i % 2);

    // CPU read of preloaded word.
    @(negedge clk);
    issue_cpu(1'b0, 16'h0010, 16'h0000);
    step3(en1, we1, a1, ca2, ka2, ke2);
    chk("rd_en_c1", en1, 1'b1);
    chk("rd_we_c1", we1, 1'b0);
    chk("rd_ack_c2", ca2, 1'b1);
    @(negedge clk);
    chk("rd_data", cpu_rdata, 16'hBEEF);
    drain();

    // Out-of-window keyboard write.
    @(negedge clk);
    issue_kbd(16'h0100, 16'h7777);
    step3(en1, we1, a1, ca2, ka2, ke2);
    chk("oow_en_c1", en1, 1'b0);
    chk("oow_ack_c2", ka2, 1'b1);
    chk("oow_err_c2", ke2, 1'b1);
    drain();
    chk("oow_mem_unchanged", mem[16'h0100], 16'h0100 ^ 16'h5A5A);

    // Window edges with default parameters.
    @(negedge clk);
    issue_kbd(16'hFFFF, 16'h00AB);
    step3(en1, we1, a1, ca2, ka2, ke2);
    chk("edge_ffff_en", en1, 1'b1);
    chk("edge_ffff_err", {ka2, ke2}, 2'b10);
    drain();
    @(negedge clk);
    issue_kbd(16'hFFEF, 16'h00CD);
    step3(en1, we1, a1, ca2, ka2, ke2);
    chk("edge_ffef_en", en1, 1'b0);
    chk("edge_ffef_err", {ka2, ke2}, 2'b11);
    drain();

    // Reset during ACCESS of a CPU write cancels it.
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555; cpu_req = 1'b1;
    @(negedge clk);
    chk("rstx_access_en", mem_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    cpu_req = 1'b0;
    chk("rstx_outputs", {mem_en, mem_we, cpu_ack, kbd_ack, kbd_err}, 5'b00000);
    chk("rstx_addr_data", {mem_addr, mem_wdata}, 32'h0000_0000);
    chk("rstx_rdata", cpu_rdata, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ack) n++;
    end
    chk("rstx_no_ack", n, 0);
    chk("rstx_mem_unchanged", mem[16'h0030], ref_mem[16'h0030]);
    issue_cpu(1'b1, 16'h0031, 16'h9999);
    step3(en1, we1, a1, ca2, ka2, ke2);
    chk("rstx_fresh_en", en1, 1'b1);
    chk("rstx_fresh_ack", ca2, 1'b1);
    drain();

    // Randomized traffic from both requesters.
    for (int it = 0; it < 40; it++) begin
      fork
        begin
          if ($urandom_range(0, 3) != 0) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue_cpu(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom));
            wait_cpu();
          end
        end
        begin
          if ($urandom_range(0, 3) != 0) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 3) == 0)
              issue_kbd(16'h1000 + 16'($urandom_range(0, 255)), 16'($urandom));
            else
              issue_kbd(16'hFFF0 + 16'($urandom_range(0, 15)), 16'($urandom));
            wait_kbd();
          end
        end
      join
    end

    repeat (3) @(negedge clk);
    chk("cpu_q_empty", cpu_q.size(), 0);
    chk("kbd_q_empty", kbd_q.size(), 0);
    bad = 0;
    for (int i = 'h0000; i < 'h0200; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_low_region", bad, 0);
    bad = 0;
    for (int i = 'h1000; i < 'h1100; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_oow_region", bad, 0);
    bad = 0;
    for (int i = 'hFFE0; i < 'h10000; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_window_region", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
